bist_multi_pattern_controller: RTL and testbench

Parametrised BIST sequencer that drives the scan-enable (mode) and status strobes for a test-per-scan session. A session applies NUM_PATTERNS patterns. Each pattern is a SCAN_LEN-cycle shift followed by a CAPTURE_CYCLES-cycle capture. A final unload shift follows the last capture, then the controller reports a pass/fail verdict from the signature comparator. It sits between the top-level test port (bist_start/abort) and the scan chain, LFSR/MISR and signature compare logic.

---
 rtl/bist_multi_pattern_controller.sv | 140 ++++++++++++++
 tb/tb_bist_multi_pattern_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_multi_pattern_controller.sv
// BIST session sequencer: INIT, then NUM_PATTERNS x (SCAN_LEN shift + CAPTURE_CYCLES
// capture), a final unload shift, FINISH (verdict sample), then DONE.
// Strobes are decoded from the state register only; pass/aborted are registered.
module bist_multi_pattern_controller #(
  parameter int SCAN_LEN       = 13,
  parameter int NUM_PATTERNS   = 2,
  parameter int CAPTURE_CYCLES = 1,
  localparam int LEN_W = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1,
  localparam int PAT_W = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bist_start,
  input  logic             abort,
  input  logic             sig_match,
  output logic             mode,
  output logic             init,
  output logic             running,
  output logic             finish,
  output logic             bist_end,
  output logic             pass,
  output logic             aborted,
  output logic [PAT_W-1:0] pattern_idx,
  output logic [LEN_W-1:0] shift_cnt
);

  localparam int CAP_W = (CAPTURE_CYCLES > 1) ? $clog2(CAPTURE_CYCLES) : 1;
  localparam logic [LEN_W-1:0] SHIFT_LAST = LEN_W'(SCAN_LEN - 1);
  localparam logic [CAP_W-1:0] CAP_LAST   = CAP_W'(CAPTURE_CYCLES - 1);
  localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    IDLE, INIT, SHIFT, CAPTURE, FINISH, DONE
  } state_t;

  state_t             state_q, state_d;
  logic               prev_start_q;
  logic [LEN_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [CAP_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [PAT_W-1:0]   pattern_idx_q, pattern_idx_d;
  logic               pass_q, pass_d;
  logic               aborted_q, aborted_d;
  logic               start_edge;
  logic               active;

  assign start_edge = bist_start & ~prev_start_q;
  assign active     = (state_q == INIT) || (state_q == SHIFT) ||
                      (state_q == CAPTURE) || (state_q == FINISH);

  // State and datapath registers; reset dominates everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_start_q  <= 1'b0;
      shift_cnt_q   <= '0;
      cap_cnt_q     <= '0;
      pattern_idx_q <= '0;
      pass_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_start_q  <= bist_start;
      shift_cnt_q   <= shift_cnt_d;
      cap_cnt_q     <= cap_cnt_d;
      pattern_idx_q <= pattern_idx_d;
      pass_q        <= pass_d;
      aborted_q     <= aborted_d;
    end
  end

  // Next-state and counter update; abort outranks counter-driven moves and freezes counters.
  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    cap_cnt_d     = cap_cnt_q;
    pattern_idx_d = pattern_idx_q;
    pass_d        = pass_q;
    aborted_d     = aborted_q;
    if (abort && active) begin
      state_d   = DONE;
      pass_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // Clearing on entry keeps the stale verdict off the bus during INIT.
          if (start_edge) begin
            state_d       = INIT;
            pass_d        = 1'b0;
            aborted_d     = 1'b0;
            pattern_idx_d = '0;
            shift_cnt_d   = '0;
            cap_cnt_d     = '0;
          end
        end
        INIT: begin
          state_d       = SHIFT;
          pass_d        = 1'b0;
          aborted_d     = 1'b0;
          pattern_idx_d = '0;
          shift_cnt_d   = '0;
          cap_cnt_d     = '0;
        end
        SHIFT: begin
          if (shift_cnt_q == SHIFT_LAST) begin
            shift_cnt_d = '0;
            state_d     = (pattern_idx_q == PAT_LAST) ? FINISH : CAPTURE;
          end else begin
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          if (cap_cnt_q == CAP_LAST) begin
            cap_cnt_d     = '0;
            pattern_idx_d = pattern_idx_q + 1'b1;
            state_d       = SHIFT;
          end else begin
            cap_cnt_d = cap_cnt_q + 1'b1;
          end
        end
        FINISH: begin
          state_d = DONE;
          pass_d  = sig_match;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign init        = (state_q == INIT);
  assign mode        = (state_q == SHIFT);
  assign running     = (state_q == SHIFT) || (state_q == CAPTURE);
  assign finish      = (state_q == FINISH);
  assign bist_end    = (state_q == DONE);
  assign pass        = pass_q;
  assign aborted     = aborted_q;
  assign pattern_idx = pattern_idx_q;
  assign shift_cnt   = shift_cnt_q;

endmodule

// File: tb/tb_bist_multi_pattern_controller.sv
// Bench: default instance and a (1,3,2) instance share stimulus; each is
// compared every cycle against a session-timeline model built from arithmetic.
module tb_bist_multi_pattern_controller;

  logic clock = 1'b0;
  logic reset, bist_start, abort, sig_match;
  always #5 clock = ~clock;

  logic       mode0, init0, run0, fin0, end0, pass0, ab0;
  logic [1:0] idx0;
  logic [3:0] cnt0;
  logic       mode1, init1, run1, fin1, end1, pass1, ab1;
  logic [1:0] idx1;
  logic [0:0] cnt1;

  bist_multi_pattern_controller u_dut0 (
    .clock(clock), .reset(reset), .bist_start(bist_start), .abort(abort),
    .sig_match(sig_match), .mode(mode0), .init(init0), .running(run0),
    .finish(fin0), .bist_end(end0), .pass(pass0), .aborted(ab0),
    .pattern_idx(idx0), .shift_cnt(cnt0));

  bist_multi_pattern_controller #(.SCAN_LEN(1), .NUM_PATTERNS(3), .CAPTURE_CYCLES(2)) u_dut1 (
    .clock(clock), .reset(reset), .bist_start(bist_start), .abort(abort),
    .sig_match(sig_match), .mode(mode1), .init(init1), .running(run1),
    .finish(fin1), .bist_end(end1), .pass(pass1), .aborted(ab1),
    .pattern_idx(idx1), .shift_cnt(cnt1));

  typedef struct {
    int init, mode, running, finish, bend, pass, ab, idx, cnt;
  } out_t;

  int PS[2] = '{13, 1};
  int PN[2] = '{2, 3};
  int PC[2] = '{1, 2};

  // model: ph 0=idle 1=session (k cycles since INIT) 2=done
  int ph[2], k[2], mpass[2], mab[2], midx[2], mcnt[2], mprev[2];
  // observed-session bookkeeping
  int in_s[2], ok[2], omodes[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic out_t model_out(input int d);
    out_t e;
    int s, n, c, j, r;
    s = PS[d]; n = PN[d]; c = PC[d];
    e = '{default: 0};
    e.pass = mpass[d]; e.ab = mab[d]; e.idx = midx[d]; e.cnt = mcnt[d];
    if (ph[d] == 2) e.bend = 1;
    else if (ph[d] == 1) begin
      if (k[d] == 0) begin
        e.init = 1; e.idx = 0; e.cnt = 0;
      end else if (k[d] <= n * (s + c)) begin
        j = k[d] - 1;
        e.idx = j / (s + c);
        r = j % (s + c);
        e.running = 1;
        if (r < s) begin e.mode = 1; e.cnt = r; end
        else e.cnt = 0;
      end else if (k[d] <= n * (s + c) + s) begin
        e.mode = 1; e.running = 1; e.idx = n;
        e.cnt = k[d] - 1 - n * (s + c);
      end else begin
        e.finish = 1; e.idx = n; e.cnt = 0;
      end
    end
    return e;
  endfunction

  function automatic void model_step(input int d);
    out_t e;
    int edge_s;
    if (reset) begin
      ph[d] = 0; k[d] = 0; mpass[d] = 0; mab[d] = 0; midx[d] = 0; mcnt[d] = 0; mprev[d] = 0;
      return;
    end
    edge_s = (bist_start && !mprev[d]) ? 1 : 0;
    mprev[d] = bist_start ? 1 : 0;
    if (ph[d] != 1) begin
      if (edge_s != 0) begin ph[d] = 1; k[d] = 0; end
    end else begin
      e = model_out(d);
      if (abort) begin
        ph[d] = 2; mpass[d] = 0; mab[d] = 1; midx[d] = e.idx; mcnt[d] = e.cnt;
      end else if (e.finish != 0) begin
        ph[d] = 2; mpass[d] = sig_match ? 1 : 0; mab[d] = 0; midx[d] = PN[d]; mcnt[d] = 0;
      end else k[d]++;
    end
  endfunction

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  function automatic out_t observe(input int d);
    out_t o;
    if (d == 0) o = '{int'(init0), int'(mode0), int'(run0), int'(fin0), int'(end0),
                      int'(pass0), int'(ab0), int'(idx0), int'(cnt0)};
    else        o = '{int'(init1), int'(mode1), int'(run1), int'(fin1), int'(end1),
                      int'(pass1), int'(ab1), int'(idx1), int'(cnt1)};
    return o;
  endfunction

  task automatic compare(input int d);
    out_t o, e;
    o = observe(d);
    e = model_out(d);
    chk($sformatf("d%0d_init", d), o.init, e.init);
    chk($sformatf("d%0d_mode", d), o.mode, e.mode);
    chk($sformatf("d%0d_running", d), o.running, e.running);
    chk($sformatf("d%0d_finish", d), o.finish, e.finish);
    chk($sformatf("d%0d_bist_end", d), o.bend, e.bend);
    chk($sformatf("d%0d_pattern_idx", d), o.idx, e.idx);
    chk($sformatf("d%0d_shift_cnt", d), o.cnt, e.cnt);
    if (ph[d] != 1) begin
      chk($sformatf("d%0d_pass", d), o.pass, e.pass);
      chk($sformatf("d%0d_aborted", d), o.ab, e.ab);
    end
    // Session length and scan-enable duty measured from the outputs alone.
    if (o.init != 0) begin
      in_s[d] = 1; ok[d] = 0; omodes[d] = 0;
    end else if (in_s[d] != 0) begin
      ok[d]++;
      omodes[d] += o.mode;
      if (o.finish != 0) begin
        chk($sformatf("d%0d_finish_latency", d), ok[d], 1 + PN[d] * (PS[d] + PC[d]) + PS[d]);
        chk($sformatf("d%0d_mode_cycles", d), omodes[d], (PN[d] + 1) * PS[d]);
        in_s[d] = 0;
      end
      if (o.bend != 0 || (o.running == 0 && o.finish == 0)) in_s[d] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic pulse_start();
    bist_start = 1'b1;
    cyc();
    bist_start = 1'b0;
  endtask

  task automatic run_until_done0(input string tag, input int maxc);
    int n = 0;
    while (!end0 && n < maxc) begin cyc(); n++; end
    chk(tag, int'(end0), 1);
  endtask

  initial begin
    reset = 1'b1; bist_start = 1'b0; abort = 1'b0; sig_match = 1'b0;
    for (int d = 0; d < 2; d++) begin in_s[d] = 0; ok[d] = 0; omodes[d] = 0; end
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Defaults: full session with matching signature.
    sig_match = 1'b1;
    pulse_start();
    run_until_done0("t1_done", 100);
    chk("t1_pass", int'(pass0), 1);

    // Held start: one session only, then a re-edge from DONE restarts.
    bist_start = 1'b1;
    repeat (100) cyc();
    chk("t2_still_done", int'(end0), 1);
    bist_start = 1'b0;
    cyc();
    bist_start = 1'b1;
    cyc();
    chk("t2_reinit", int'(init0), 1);
    bist_start = 1'b0;

    // Signature mismatch: fail verdict held in DONE.
    sig_match = 1'b0;
    run_until_done0("t3_done", 100);
    chk("t3_pass", int'(pass0), 0);
    chk("t3_aborted", int'(ab0), 0);
    repeat (10) cyc();
    chk("t3_hold", int'(pass0), 0);

    // Abort at pattern 1, shift 5: counters freeze.
    sig_match = 1'b1;
    pulse_start();
    begin
      int n = 0;
      while (!(idx0 == 2'd1 && cnt0 == 4'd5 && mode0) && n < 100) begin cyc(); n++; end
      chk("t4_reach", n < 100 ? 1 : 0, 1);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4_done", int'(end0), 1);
    chk("t4_aborted", int'(ab0), 1);
    chk("t4_idx", int'(idx0), 1);
    chk("t4_cnt", int'(cnt0), 5);

    // Reset during capture, then a clean session.
    pulse_start();
    begin
      int n = 0;
      while (!(run0 && !mode0) && n < 100) begin cyc(); n++; end
      chk("t5_reach", n < 100 ? 1 : 0, 1);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_idle", int'({init0, mode0, run0, fin0, end0, pass0, ab0, idx0, cnt0}), 0);
    pulse_start();
    run_until_done0("t5_done", 100);
    chk("t5_pass", int'(pass0), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bist_start = ~bist_start;
      abort     = ($urandom_range(0, 79) == 0);
      sig_match = $urandom_range(0, 1) != 0;
      reset     = ($urandom_range(0, 699) == 0);
      cyc();
    end
    reset = 1'b0; abort = 1'b0; bist_start = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
